// File: rtl/arb_pkg.sv
// Shared constants, state encoding and scan-result payload for the
// eight-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Result of one rotate-priority scan: whether anyone asked, and who won.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/decoder3_8.sv
// Binary-to-one-hot decoder expanding the registered owner index into a
// grant vector.
module decoder3_8 (
    input  logic [2:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'(1) << a;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a one-cycle dead gap between
// owners and a hold-time watchdog bounding each grant's tenure.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int unsigned        CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    pick_t            pick_c;
    logic             owner_req_c;
    logic             wd_hit_c;
    logic             release_c;
    logic [N_REQ-1:0] dec_y;

    // First set request at or after ptr, wrapping past client 7 to client 0.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] r,
                                      input logic [IDX_W-1:0] p);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res  = '0;
        cand = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = p + IDX_W'(i);
            if (!res.found && r[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    always_comb begin
        pick_c      = rr_pick(req, ptr_q);
        owner_req_c = req[idx_q];
        wd_hit_c    = (cnt_q == CNT_LAST);
        release_c   = done || !owner_req_c || wd_hit_c;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE, GAP: begin
                if (pick_c.found) begin
                    state_d = GRANT;
                    idx_d   = pick_c.idx;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_d   = GAP;
                    ptr_d     = idx_q + IDX_W'(1);
                    idx_d     = '0;
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                    // A voluntary release in the same cycle outranks the watchdog.
                    timeout_d = wd_hit_c && !done && owner_req_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    decoder3_8 u_dec (
        .a (idx_q),
        .y (dec_y)
    );

    // Gating with the valid flag lets an async reset clear grant instantly.
    assign grant       = dec_y & {N_REQ{valid_q}};
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (HOLD_MAX=4) with hand-computed expectations.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int vectors;
    int miscompares;

    rr_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = 8'hFF;
        done        = 1'b0;

        // Reset held with every client requesting.
        cyc();
        cyc();
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", {7'b0, grant_valid}, 8'h00);
        chk("rst_idx", {5'b0, grant_idx}, 8'h00);
        chk("rst_timeout", {7'b0, timeout}, 8'h00);
        rst_n = 1'b1;
        cyc();
        chk("first_grant", grant, 8'h01);
        chk("first_idx", {5'b0, grant_idx}, 8'h00);
        chk("first_valid", {7'b0, grant_valid}, 8'h01);

        // Single requester, done on its third grant cycle.
        done = 1'b1;
        cyc();
        chk("gap_after_first", grant, 8'h00);
        req  = 8'h04;
        done = 1'b0;
        cyc();
        chk("c2_cyc1", grant, 8'h04);
        chk("c2_idx", {5'b0, grant_idx}, 8'h02);
        cyc();
        chk("c2_cyc2", grant, 8'h04);
        cyc();
        chk("c2_cyc3", grant, 8'h04);
        done = 1'b1;
        cyc();
        chk("c2_gap", grant, 8'h00);
        chk("c2_gap_idx", {5'b0, grant_idx}, 8'h00);
        chk("c2_gap_timeout", {7'b0, timeout}, 8'h00);
        done = 1'b0;
        cyc();
        chk("c2_regrant", grant, 8'h04);
        done = 1'b1;
        cyc();
        req  = 8'h00;
        done = 1'b0;
        cyc();
        chk("idle_valid", {7'b0, grant_valid}, 8'h00);

        // Reset pulse between edges returns ptr to 0, then full rotation.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req  = 8'hFF;
        done = 1'b1;
        cyc();
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("wrap_grant%0d", i), grant, 8'(1) << (i % 8));
            cyc();
            chk($sformatf("wrap_gap%0d", i), grant, 8'h00);
            if (i < 8) cyc();
        end
        req  = 8'h00;
        done = 1'b0;
        cyc();
        chk("wrap_idle", {7'b0, grant_valid}, 8'h00);

        // Watchdog expiry with HOLD_MAX=4.
        req = 8'h10;
        cyc();
        chk("wd_cyc1", grant, 8'h10);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk($sformatf("wd_cyc%0d", i), grant, 8'h10);
            chk($sformatf("wd_to%0d", i), {7'b0, timeout}, 8'h00);
        end
        cyc();
        chk("wd_gap_grant", grant, 8'h00);
        chk("wd_gap_timeout", {7'b0, timeout}, 8'h01);
        cyc();
        chk("wd_regrant", grant, 8'h10);
        chk("wd_regrant_timeout", {7'b0, timeout}, 8'h00);
        req = 8'h00;
        cyc();
        chk("drop_idle_timeout", {7'b0, timeout}, 8'h00);
        cyc();

        // done coinciding with watchdog: no timeout.
        req = 8'h21;
        cyc();
        chk("co_first", grant, 8'h20);
        done = 1'b1;
        cyc();
        chk("co_gap0", grant, 8'h00);
        done = 1'b0;
        cyc();
        chk("co_own0_c1", grant, 8'h01);
        cyc();
        chk("co_own0_c2", grant, 8'h01);
        cyc();
        chk("co_own0_c3", grant, 8'h01);
        cyc();
        chk("co_own0_c4", grant, 8'h01);
        done = 1'b1;
        cyc();
        chk("co_gap_grant", grant, 8'h00);
        chk("co_gap_timeout", {7'b0, timeout}, 8'h00);
        done = 1'b0;
        cyc();
        chk("co_next", grant, 8'h20);
        chk("co_next_idx", {5'b0, grant_idx}, 8'h05);
        cyc();
        chk("drop_hold", grant, 8'h20);
        req = 8'h01;
        cyc();
        chk("drop_gap", grant, 8'h00);
        chk("drop_timeout", {7'b0, timeout}, 8'h00);
        cyc();
        chk("drop_next", grant, 8'h01);

        // Async reset during grant 8'h80.
        req = 8'h80;
        cyc();
        chk("r80_gap", grant, 8'h00);
        cyc();
        chk("r80_grant", grant, 8'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r80_async_grant", grant, 8'h00);
        chk("r80_async_valid", {7'b0, grant_valid}, 8'h00);
        cyc();
        req   = 8'h81;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_grant", grant, 8'h01);
        chk("post_rst_idx", {5'b0, grant_idx}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
